// File: rtl/op_downscale.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : op_downscale                                                 |
// | Description : CORDIC output stage. Rounds off the guard LSBs (half-up),    |
// |               range-limits to DATA_WIDTH and counts overflowed beats.      |
// |               Build option OP_DOWNSCALE_SAT_EN: clamp instead of wrap.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module op_downscale #(
    parameter int DATA_WIDTH   = 16,
    parameter int CORDIC_WIDTH = 22,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [CORDIC_WIDTH-1:0] x_in,
    input  logic [CORDIC_WIDTH-1:0] y_in,
    input  logic                    in_vld,
    output logic                    in_rdy,
    output logic [DATA_WIDTH-1:0]   x_out,
    output logic [DATA_WIDTH-1:0]   y_out,
    output logic                    op_vld,
    input  logic                    out_rdy,
    output logic                    ovf,
    input  logic                    clr_cnt,
    output logic [CNT_WIDTH-1:0]    ovf_cnt
);

    localparam int c_frac = CORDIC_WIDTH - DATA_WIDTH;
    localparam int c_sw   = CORDIC_WIDTH + 1;
    localparam logic [c_sw-1:0] c_rnd = {{(c_sw-1){1'b0}}, 1'b1} << (c_frac - 1);

    logic [c_sw-1:0]       s1_x_q, s1_x_d;
    logic [c_sw-1:0]       s1_y_q, s1_y_d;
    logic                  s1_vld_q, s1_vld_d;
    logic [DATA_WIDTH-1:0] x_out_q, x_out_d;
    logic [DATA_WIDTH-1:0] y_out_q, y_out_d;
    logic                  op_vld_q, op_vld_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  w_s2_adv;
    logic                  w_accept;
    logic [DATA_WIDTH:0]   w_qx;
    logic [DATA_WIDTH:0]   w_qy;
    logic                  w_ovf_x;
    logic                  w_ovf_y;
    logic                  w_ovf;

    // Lane result for an out-of-range quotient: clamp or keep the low bits.
    function automatic logic [DATA_WIDTH-1:0] limit(input logic [DATA_WIDTH:0] q);
        logic [DATA_WIDTH-1:0] r;
        r = q[DATA_WIDTH-1:0];
`ifdef OP_DOWNSCALE_SAT_EN
        if (q[DATA_WIDTH] != q[DATA_WIDTH-1]) begin
            r = q[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`else
        r = q[DATA_WIDTH-1:0];
`endif
        return r;
    endfunction

    assign w_s2_adv = ~op_vld_q | out_rdy;
    assign in_rdy   = ~s1_vld_q | w_s2_adv;
    assign w_accept = in_vld & in_rdy;

    // Arithmetic shift by c_frac is just the upper DATA_WIDTH+1 bits.
    assign w_qx    = s1_x_q[c_sw-1:c_frac];
    assign w_qy    = s1_y_q[c_sw-1:c_frac];
    assign w_ovf_x = w_qx[DATA_WIDTH] ^ w_qx[DATA_WIDTH-1];
    assign w_ovf_y = w_qy[DATA_WIDTH] ^ w_qy[DATA_WIDTH-1];
    assign w_ovf   = w_ovf_x | w_ovf_y;

    always_comb begin
        s1_x_d   = s1_x_q;
        s1_y_d   = s1_y_q;
        s1_vld_d = s1_vld_q;
        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        op_vld_d = op_vld_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        if (w_accept) begin
            s1_x_d   = {x_in[CORDIC_WIDTH-1], x_in} + c_rnd;
            s1_y_d   = {y_in[CORDIC_WIDTH-1], y_in} + c_rnd;
            s1_vld_d = 1'b1;
        end else if (w_s2_adv) begin
            s1_vld_d = 1'b0;
        end

        if (w_s2_adv) begin
            op_vld_d = s1_vld_q;
            ovf_d    = s1_vld_q & w_ovf;
            if (s1_vld_q) begin
                x_out_d = limit(w_qx);
                y_out_d = limit(w_qy);
            end
        end

        // Clear has priority over a same-cycle increment.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (w_s2_adv && s1_vld_q && w_ovf && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_vld_q <= 1'b0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            op_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_x_q   <= s1_x_d;
            s1_y_q   <= s1_y_d;
            s1_vld_q <= s1_vld_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
            op_vld_q <= op_vld_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign x_out   = x_out_q;
    assign y_out   = y_out_q;
    assign op_vld  = op_vld_q;
    assign ovf     = ovf_q;
    assign ovf_cnt = cnt_q;

endmodule
`default_nettype wire
